// File: rtl/bitcoin_nonce_sweep_pkg.sv
// Shared types and SHA-256 constants for the nonce sweep engine.
package bitcoin_nonce_sweep_pkg;

   localparam int HEADER_WORDS = 19;

   typedef enum logic [2:0] {
      S_IDLE        = 3'd0,
      S_READ        = 3'd1,
      S_BATCH_START = 3'd2,
      S_BATCH_WAIT  = 3'd3,
      S_WRITE       = 3'd4,
      S_DONE        = 3'd5
   } state_e;

   localparam logic [31:0] SHA_K [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   localparam logic [31:0] SHA_IV [8] = '{
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   function automatic logic [31:0] rotr(input logic [31:0] x, input logic [4:0] n);
      return (x >> n) | (x << (6'd32 - {1'b0, n}));
   endfunction

   function automatic logic [31:0] bsig0(input logic [31:0] x);
      return rotr(x, 5'd2) ^ rotr(x, 5'd13) ^ rotr(x, 5'd22);
   endfunction

   function automatic logic [31:0] bsig1(input logic [31:0] x);
      return rotr(x, 5'd6) ^ rotr(x, 5'd11) ^ rotr(x, 5'd25);
   endfunction

   function automatic logic [31:0] ssig0(input logic [31:0] x);
      return rotr(x, 5'd7) ^ rotr(x, 5'd18) ^ (x >> 3'd3);
   endfunction

   function automatic logic [31:0] ssig1(input logic [31:0] x);
      return rotr(x, 5'd17) ^ rotr(x, 5'd19) ^ (x >> 4'd10);
   endfunction

   function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f, input logic [31:0] g);
      return (e & f) ^ (~e & g);
   endfunction

   function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
      return (a & b) ^ (a & c) ^ (b & c);
   endfunction

endpackage

// File: rtl/bitcoin_nonce_sweep_if.sv
// Word-addressed shared memory bus between the sweep engine and memory.
interface bitcoin_nonce_sweep_if #(parameter int ADDR_W = 16);
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_write_data;
   logic [31:0]       mem_read_data;

   modport master (output mem_we, output mem_addr, output mem_write_data, input mem_read_data);
   modport slave  (input mem_we, input mem_addr, input mem_write_data, output mem_read_data);
endinterface

// File: rtl/bitcoin_nonce_sweep_sha_core.sv
// Iterative double SHA-256 of an 80-byte header+nonce, one round per cycle; reports final H0.
module bitcoin_sha_core
   import bitcoin_nonce_sweep_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] header [HEADER_WORDS],
   input  logic [31:0] nonce,
   output logic        done,
   output logic [31:0] h0
);

   logic [31:0] v_q [8], v_d [8], hs_q [8], hs_d [8], nv_s [8], dig_s [8];
   logic [31:0] w_q [16], w_d [16];
   logic [31:0] nonce_q, nonce_d, h0_q, h0_d, t1_s, t2_s, wn_s;
   logic [5:0]  rnd_q, rnd_d;
   logic [1:0]  blk_q, blk_d;
   logic        busy_q, busy_d, done_q, done_d;

   // Round datapath; blk_q selects first block, second block, or the re-hash of the digest.
   always_comb begin
      t1_s = v_q[7] + bsig1(v_q[4]) + ch(v_q[4], v_q[5], v_q[6]) + SHA_K[rnd_q] + w_q[0];
      t2_s = bsig0(v_q[0]) + maj(v_q[0], v_q[1], v_q[2]);
      nv_s[0] = t1_s + t2_s;
      for (int i = 1; i < 8; i++) nv_s[i] = v_q[i-1];
      nv_s[4] = v_q[3] + t1_s;
      for (int i = 0; i < 8; i++) dig_s[i] = hs_q[i] + nv_s[i];
      wn_s = ssig1(w_q[14]) + w_q[9] + ssig0(w_q[1]) + w_q[0];

      v_d = v_q; hs_d = hs_q; w_d = w_q;
      nonce_d = nonce_q; h0_d = h0_q; rnd_d = rnd_q; blk_d = blk_q;
      busy_d = busy_q; done_d = done_q;

      if (start) begin
         nonce_d = nonce;
         hs_d    = SHA_IV;
         v_d     = SHA_IV;
         for (int i = 0; i < 16; i++) w_d[i] = header[i];
         rnd_d  = 6'd0;
         blk_d  = 2'd0;
         busy_d = 1'b1;
         done_d = 1'b0;
      end else if (busy_q) begin
         v_d = nv_s;
         for (int i = 0; i < 15; i++) w_d[i] = w_q[i+1];
         w_d[15] = wn_s;
         rnd_d   = rnd_q + 6'd1;
         if (rnd_q == 6'd63) begin
            for (int i = 0; i < 16; i++) w_d[i] = 32'h0;
            case (blk_q)
               2'd0: begin
                  hs_d = dig_s;
                  v_d  = dig_s;
                  w_d[0] = header[16]; w_d[1] = header[17]; w_d[2] = header[18];
                  w_d[3] = nonce_q;    w_d[4] = 32'h8000_0000; w_d[15] = 32'h0000_0280;
                  blk_d = 2'd1;
               end
               2'd1: begin
                  hs_d = SHA_IV;
                  v_d  = SHA_IV;
                  for (int i = 0; i < 8; i++) w_d[i] = dig_s[i];
                  w_d[8] = 32'h8000_0000; w_d[15] = 32'h0000_0100;
                  blk_d = 2'd2;
               end
               default: begin
                  h0_d   = dig_s[0];
                  busy_d = 1'b0;
                  done_d = 1'b1;
               end
            endcase
         end else begin
            blk_d = blk_q;
         end
      end else begin
         done_d = done_q;
      end
   end

   // State registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 8; i++) begin v_q[i] <= 32'h0; hs_q[i] <= 32'h0; end
         for (int i = 0; i < 16; i++) w_q[i] <= 32'h0;
         nonce_q <= 32'h0; h0_q <= 32'h0; rnd_q <= 6'd0; blk_q <= 2'd0;
         busy_q  <= 1'b0;  done_q <= 1'b0;
      end else begin
         v_q <= v_d; hs_q <= hs_d; w_q <= w_d;
         nonce_q <= nonce_d; h0_q <= h0_d; rnd_q <= rnd_d; blk_q <= blk_d;
         busy_q  <= busy_d;  done_q <= done_d;
      end
   end

   assign done = done_q;
   assign h0   = h0_q;

endmodule

// File: rtl/bitcoin_nonce_sweep.sv
// Reads the block header once, then sweeps a nonce range in batches of NUM_CORES hash engines.
module bitcoin_nonce_sweep
   import bitcoin_nonce_sweep_pkg::*;
#(
   parameter int NUM_CORES = 16,
   parameter int ADDR_W    = 16,
   parameter int NONCE_W   = 32
)(
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               search_mode,
   input  logic [ADDR_W-1:0]  message_addr,
   input  logic [ADDR_W-1:0]  output_addr,
   input  logic [NONCE_W-1:0] nonce_base,
   input  logic [NONCE_W-1:0] nonce_count,
   input  logic [31:0]        target,
   output logic               done,
   output logic               found,
   output logic [NONCE_W-1:0] found_nonce,
   output logic               mem_clk,
   bitcoin_nonce_sweep_if.master mem
);

   localparam int LANE_W = $clog2(NUM_CORES + 1);

   state_e             state_q, state_d;
   logic [4:0]         rd_cnt_q, rd_cnt_d;
   logic [31:0]        header_q [HEADER_WORDS], header_d [HEADER_WORDS];
   logic               mode_q, mode_d;
   logic [ADDR_W-1:0]  msg_q, msg_d, out_q, out_d, mem_addr_q, mem_addr_d;
   logic [NONCE_W-1:0] base_q, base_d, cnt_q, cnt_d, found_nonce_q, found_nonce_d;
   logic [31:0]        tgt_q, tgt_d, mem_wdata_q, mem_wdata_d;
   logic [NONCE_W:0]   idx_q, idx_d, remaining_s, batch_next_s;
   logic [LANE_W-1:0]  lanes_q, lanes_d, lane_q, lane_d, lanes_s, hit_lane_s;
   logic               done_q, done_d, found_q, found_d, mem_we_q, mem_we_d;
   logic               accept_s, all_done_s, hit_s;
   logic [31:0]        sel_h0_s, hit_h0_s;
   logic [NONCE_W-1:0] hit_nonce_s;
   logic [NUM_CORES-1:0] core_start_s, core_done_s;
   logic [31:0]        core_h0_s [NUM_CORES];

   for (genvar k = 0; k < NUM_CORES; k++) begin : g_core
      assign core_start_s[k] = (state_q == S_BATCH_START) && (LANE_W'(k) < lanes_s);
      bitcoin_sha_core u_core (
         .clk    (clk),
         .reset  (reset),
         .start  (core_start_s[k]),
         .header (header_q),
         .nonce  (base_q + idx_q[NONCE_W-1:0] + NONCE_W'(k)),
         .done   (core_done_s[k]),
         .h0     (core_h0_s[k])
      );
   end

   // Batch bookkeeping: lane count, completion, write-lane select and lowest hitting lane.
   always_comb begin
      remaining_s  = {1'b0, cnt_q} - idx_q;
      lanes_s      = (remaining_s >= (NONCE_W+1)'(NUM_CORES)) ? LANE_W'(NUM_CORES)
                                                              : remaining_s[LANE_W-1:0];
      batch_next_s = idx_q + (NONCE_W+1)'(lanes_q);
      all_done_s   = 1'b1;
      sel_h0_s     = 32'h0;
      hit_s        = 1'b0;
      hit_lane_s   = '0;
      hit_h0_s     = 32'h0;
      // Descending scan so the lowest hitting lane is the one that sticks.
      for (int k = NUM_CORES - 1; k >= 0; k--) begin
         all_done_s = all_done_s & (core_done_s[k] | (LANE_W'(k) >= lanes_q));
         sel_h0_s   = (LANE_W'(k) == lane_q) ? core_h0_s[k] : sel_h0_s;
         if ((LANE_W'(k) < lanes_q) && (core_h0_s[k] < tgt_q)) begin
            hit_s      = 1'b1;
            hit_lane_s = LANE_W'(k);
            hit_h0_s   = core_h0_s[k];
         end else begin
            hit_s = hit_s;
         end
      end
      hit_nonce_s = base_q + idx_q[NONCE_W-1:0] + NONCE_W'(hit_lane_s);
   end

   assign accept_s = start && ((state_q == S_IDLE) || (state_q == S_DONE));

   // Control FSM next-state and registered-output logic.
   always_comb begin
      state_d = state_q; rd_cnt_d = rd_cnt_q; header_d = header_q;
      mode_d = mode_q; msg_d = msg_q; out_d = out_q; base_d = base_q; cnt_d = cnt_q; tgt_d = tgt_q;
      idx_d = idx_q; lanes_d = lanes_q; lane_d = lane_q;
      done_d = done_q; found_d = found_q; found_nonce_d = found_nonce_q;
      mem_we_d = 1'b0; mem_addr_d = mem_addr_q; mem_wdata_d = mem_wdata_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (accept_s) begin
               mode_d = search_mode; msg_d = message_addr; out_d = output_addr;
               base_d = nonce_base;  cnt_d = nonce_count;  tgt_d = target;
               done_d = 1'b0; found_d = 1'b0; idx_d = '0;
               if (nonce_count == '0) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d    = S_READ;
                  rd_cnt_d   = 5'd0;
                  mem_addr_d = message_addr;
               end
            end else begin
               state_d = state_q;
            end
         end
         S_READ: begin
            rd_cnt_d   = rd_cnt_q + 5'd1;
            mem_addr_d = (rd_cnt_q < 5'd18) ? msg_q + ADDR_W'(rd_cnt_q + 5'd1) : mem_addr_q;
            if (rd_cnt_q >= 5'd2) header_d[rd_cnt_q - 5'd2] = mem.mem_read_data;
            else header_d = header_q;
            state_d = (rd_cnt_q == 5'd20) ? S_BATCH_START : S_READ;
         end
         S_BATCH_START: begin
            lanes_d = lanes_s;
            state_d = S_BATCH_WAIT;
         end
         S_BATCH_WAIT: begin
            lane_d  = '0;
            state_d = all_done_s ? S_WRITE : S_BATCH_WAIT;
         end
         S_WRITE: begin
            if (!mode_q || (lane_q == '0 && !hit_s)) begin
               mem_we_d    = !mode_q;
               mem_addr_d  = !mode_q ? out_q + ADDR_W'(idx_q) + ADDR_W'(lane_q) : mem_addr_q;
               mem_wdata_d = !mode_q ? sel_h0_s : mem_wdata_q;
               lane_d      = lane_q + LANE_W'(1);
               if (mode_q || lane_q == lanes_q - LANE_W'(1)) begin
                  idx_d   = batch_next_s;
                  done_d  = (batch_next_s >= {1'b0, cnt_q});
                  state_d = (batch_next_s >= {1'b0, cnt_q}) ? S_DONE : S_BATCH_START;
               end else begin
                  state_d = S_WRITE;
               end
            end else if (lane_q == '0) begin
               mem_we_d    = 1'b1;
               mem_addr_d  = out_q;
               mem_wdata_d = hit_nonce_s;
               lane_d      = LANE_W'(1);
            end else begin
               mem_we_d      = 1'b1;
               mem_addr_d    = out_q + ADDR_W'(1);
               mem_wdata_d   = hit_h0_s;
               found_d       = 1'b1;
               found_nonce_d = hit_nonce_s;
               done_d        = 1'b1;
               state_d       = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Control and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE; rd_cnt_q <= 5'd0;
         for (int i = 0; i < HEADER_WORDS; i++) header_q[i] <= 32'h0;
         mode_q <= 1'b0; msg_q <= '0; out_q <= '0; base_q <= '0; cnt_q <= '0; tgt_q <= 32'h0;
         idx_q <= '0; lanes_q <= '0; lane_q <= '0;
         done_q <= 1'b0; found_q <= 1'b0; found_nonce_q <= '0;
         mem_we_q <= 1'b0; mem_addr_q <= '0; mem_wdata_q <= 32'h0;
      end else begin
         state_q <= state_d; rd_cnt_q <= rd_cnt_d; header_q <= header_d;
         mode_q <= mode_d; msg_q <= msg_d; out_q <= out_d; base_q <= base_d; cnt_q <= cnt_d; tgt_q <= tgt_d;
         idx_q <= idx_d; lanes_q <= lanes_d; lane_q <= lane_d;
         done_q <= done_d; found_q <= found_d; found_nonce_q <= found_nonce_d;
         mem_we_q <= mem_we_d; mem_addr_q <= mem_addr_d; mem_wdata_q <= mem_wdata_d;
      end
   end

   assign done               = done_q;
   assign found              = found_q;
   assign found_nonce        = found_nonce_q;
   assign mem_clk            = clk;
   assign mem.mem_we         = mem_we_q;
   assign mem.mem_addr       = mem_addr_q;
   assign mem.mem_write_data = mem_wdata_q;

endmodule

// File: tb/tb_bitcoin_nonce_sweep.sv
// Directed/randomised bench for bitcoin_nonce_sweep against a textbook double-SHA-256 model.
module tb_bitcoin_nonce_sweep;

   localparam int NC = 16;
   localparam int AW = 16;
   localparam logic [15:0] MSG = 16'h0100;

   localparam logic [31:0] KT [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };
   localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                  32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

   logic clk = 1'b0, reset = 1'b1, start = 1'b0, search_mode = 1'b0;
   logic [AW-1:0] message_addr = MSG, output_addr = 16'h0;
   logic [31:0] nonce_base = 32'h0, nonce_count = 32'h0, target = 32'h0;
   logic done, found, mem_clk;
   logic [31:0] found_nonce;

   bitcoin_nonce_sweep_if #(.ADDR_W(AW)) mem_bus ();

   bitcoin_nonce_sweep #(.NUM_CORES(NC), .ADDR_W(AW), .NONCE_W(32)) dut (
      .clk(clk), .reset(reset), .start(start), .search_mode(search_mode),
      .message_addr(message_addr), .output_addr(output_addr),
      .nonce_base(nonce_base), .nonce_count(nonce_count), .target(target),
      .done(done), .found(found), .found_nonce(found_nonce),
      .mem_clk(mem_clk), .mem(mem_bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   logic [31:0] hdr [19];
   logic [31:0] mem [0:65535];
   logic [31:0] rd_p1;
   logic [15:0] wr_a [$];
   logic [31:0] wr_d [$];

   // Two-cycle read latency memory; every write is logged for later checking.
   always @(posedge clk) begin
      rd_p1 <= mem[mem_bus.mem_addr];
      mem_bus.mem_read_data <= rd_p1;
      if (mem_bus.mem_we) begin
         wr_a.push_back(mem_bus.mem_addr);
         wr_d.push_back(mem_bus.mem_write_data);
      end
   end

   function automatic logic [31:0] rr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
      logic [31:0] w [64];
      logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
      for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
      for (int t = 16; t < 64; t++)
         w[t] = (rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
              + (rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
      {a, b, c, d, e, f, g, h} = hin;
      for (int t = 0; t < 64; t++) begin
         t1 = h + (rr(e, 6) ^ rr(e, 11) ^ rr(e, 25)) + ((e & f) ^ (~e & g)) + KT[t] + w[t];
         t2 = (rr(a, 2) ^ rr(a, 13) ^ rr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
         h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
      end
      return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
              hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
   endfunction

   // H0 of SHA256(SHA256(header || nonce)) for the 80-byte message.
   function automatic logic [31:0] h0_of(input logic [31:0] n);
      logic [511:0] b1, b2, b3;
      logic [255:0] s;
      b1 = '0; b2 = '0; b3 = '0;
      for (int i = 0; i < 16; i++) b1[511 - 32*i -: 32] = hdr[i];
      b2[511:384] = {hdr[16], hdr[17], hdr[18], n};
      b2[383:352] = 32'h8000_0000;
      b2[31:0]    = 32'h0000_0280;
      s = compress(compress(IV, b1), b2);
      b3[511:256] = s;
      b3[255:224] = 32'h8000_0000;
      b3[31:0]    = 32'h0000_0100;
      s = compress(IV, b3);
      return s[255:224];
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic load_header();
      for (int i = 0; i < 19; i++) begin
         hdr[i] = $urandom;
         mem[MSG + 16'(i)] = hdr[i];
      end
   endtask

   task automatic launch(input logic mode, input logic [15:0] out, input logic [31:0] base,
                         input logic [31:0] cnt, input logic [31:0] tgt);
      @(negedge clk);
      wr_a.delete(); wr_d.delete();
      search_mode = mode; output_addr = out; nonce_base = base; nonce_count = cnt; target = tgt;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (!done && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("done_wait", {31'h0, done}, 32'h1);
      repeat (3) @(negedge clk);
   endtask

   task automatic check_dump(input string tag, input logic [15:0] out, input logic [31:0] base, input int cnt);
      check({tag, "_wr_count"}, 32'(wr_a.size()), 32'(cnt));
      check({tag, "_found"}, {31'h0, found}, 32'h0);
      for (int i = 0; i < cnt && i < wr_a.size(); i++) begin
         check($sformatf("%s_addr%0d", tag, i), {16'h0, wr_a[i]}, {16'h0, out + 16'(i)});
         check($sformatf("%s_data%0d", tag, i), wr_d[i], h0_of(base + 32'(i)));
      end
   endtask

   task automatic check_search(input string tag, input logic [15:0] out, input logic [31:0] base,
                               input int cnt, input logic [31:0] tgt);
      logic hit = 1'b0;
      logic [31:0] hn = 32'h0, hh = 32'h0, h;
      for (int i = 0; i < cnt && !hit; i++) begin
         h = h0_of(base + 32'(i));
         if (h < tgt) begin hit = 1'b1; hn = base + 32'(i); hh = h; end
      end
      check({tag, "_found"}, {31'h0, found}, {31'h0, hit});
      check({tag, "_wr_count"}, 32'(wr_a.size()), hit ? 32'd2 : 32'd0);
      if (hit && wr_a.size() == 2) begin
         check({tag, "_found_nonce"}, found_nonce, hn);
         check({tag, "_addr0"}, {16'h0, wr_a[0]}, {16'h0, out});
         check({tag, "_nonce"}, wr_d[0], hn);
         check({tag, "_addr1"}, {16'h0, wr_a[1]}, {16'h0, out + 16'd1});
         check({tag, "_h0"}, wr_d[1], hh);
      end
   endtask

   initial begin
      logic [255:0] abc;
      logic [31:0] rb;
      int rc;
      int budget;
      logic [511:0] abc_blk;
      abc_blk = '0;
      abc_blk[511:480] = 32'h6162_6380;
      abc_blk[31:0]    = 32'h0000_0018;
      abc = compress(IV, abc_blk);
      check("model_abc_w0", abc[255:224], 32'hba7816bf);
      check("model_abc_w7", abc[31:0], 32'hf20015ad);

      budget = 3000;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst_done", {31'h0, done}, 32'h0);
      check("rst_found", {31'h0, found}, 32'h0);
      check("rst_found_nonce", found_nonce, 32'h0);
      check("rst_mem_we", {31'h0, mem_bus.mem_we}, 32'h0);
      check("rst_mem_addr", {16'h0, mem_bus.mem_addr}, 32'h0);
      check("rst_mem_wdata", mem_bus.mem_write_data, 32'h0);

      load_header();
      launch(1'b0, 16'h2000, 32'h0, 32'd16, 32'h0);
      wait_done(budget);
      check_dump("dump16", 16'h2000, 32'h0, 16);

      load_header();
      launch(1'b0, 16'h3000, 32'hFFFF_FFFE, 32'd20, 32'h0);
      wait_done(budget);
      check_dump("dump_wrap", 16'h3000, 32'hFFFF_FFFE, 20);

      load_header();
      launch(1'b1, 16'h4000, 32'd100, 32'd40, 32'hFFFF_FFFF);
      wait_done(budget);
      check_search("search_hit0", 16'h4000, 32'd100, 40, 32'hFFFF_FFFF);

      load_header();
      launch(1'b1, 16'h4100, 32'd7, 32'd40, 32'h0);
      wait_done(budget);
      check_search("search_none", 16'h4100, 32'd7, 40, 32'h0);

      // Zero-length run: done must rise within two cycles of start with no writes.
      launch(1'b0, 16'h5000, 32'd5, 32'd0, 32'h0);
      rc = 0;
      while (!done && rc < 2) begin @(negedge clk); rc++; end
      check("cnt0_done", {31'h0, done}, 32'h1);
      repeat (3) @(negedge clk);
      check("cnt0_wr_count", 32'(wr_a.size()), 32'd0);

      load_header();
      rb = $urandom;
      rc = $urandom_range(17, 33);
      launch(1'b0, 16'hFFF8, rb, 32'(rc), 32'h0);
      wait_done(budget);
      check_dump("rand_dump", 16'hFFF8, rb, rc);

      load_header();
      rb = $urandom;
      launch(1'b1, 16'h6000, rb, 32'd48, 32'h1000_0000);
      wait_done(budget);
      check_search("rand_search", 16'h6000, rb, 48, 32'h1000_0000);

      load_header();
      rb = $urandom;
      launch(1'b0, 16'h7000, rb, 32'd16, 32'h0);
      repeat (60) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      repeat (300) @(negedge clk);
      check("abort_wr_count", 32'(wr_a.size()), 32'd0);
      check("abort_done", {31'h0, done}, 32'h0);
      launch(1'b0, 16'h7000, rb, 32'd16, 32'h0);
      wait_done(budget);
      check_dump("after_abort", 16'h7000, rb, 16);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/bitcoin_nonce_sweep.md
Name: bitcoin_nonce_sweep

Overview:
Parametrised successor to the fixed 16-nonce hasher. It reads the 19-word block header from memory once. It then sweeps an arbitrary nonce range [nonce_base, nonce_base+nonce_count) in batches of NUM_CORES parallel double-SHA256 engines. It runs in one of two modes: dump every H0 word to memory, or search for the first nonce whose H0 is below a target. It sits between the shared word-addressed memory and the top-level test harness.

Parameters:
NUM_CORES, 16, parallel hash engines per batch (1..32)
ADDR_W, 16, memory address width
NONCE_W, 32, nonce and counter width

Ports:
clk  in  1  single system clock; mem_clk = clk
reset  in  1  reset
start  in  1  launch request, sampled in IDLE/DONE only
search_mode  in  1  0 = dump all H0, 1 = search below target; latched at start
message_addr  in  ADDR_W  header base address
output_addr  in  ADDR_W  result base address
nonce_base  in  32  first nonce
nonce_count  in  32  number of nonces to hash
target  in  32  search threshold, unsigned
done  out  1  level; run complete
found  out  1  search hit; valid when done=1
found_nonce  out  32  winning nonce; valid when found=1
mem_clk  out  1  equals clk
mem_we  out  1  write strobe
mem_addr  out  ADDR_W  memory address
mem_write_data  out  32  write data
mem_read_data  in  32  read data, valid 2 cycles after mem_addr is driven

Behaviour:
- Reset: one clock; reset is synchronous and active-high. On reset: state=IDLE; done, found and mem_we = 0; found_nonce, mem_addr and mem_write_data = 0; all core starts low. Reset mid-run aborts at the next edge, with no further writes.
- start, search_mode, addresses, nonce_base, nonce_count and target are latched on the accepting edge. start outside IDLE/DONE is ignored. Acceptance clears done and found.
- States: IDLE -> READ -> BATCH_START -> BATCH_WAIT -> WRITE -> (BATCH_START | DONE). DONE holds done=1 until the next start.
- READ: issue message_addr+0..18 on consecutive cycles. Capture words 2 cycles later into the header file. Total 21 cycles. mem_we=0 throughout.
- nonce_count=0: skip READ and go straight to DONE next cycle, with found=0 and no writes.
- BATCH_START: core k gets nonce (nonce_base + idx + k) mod 2^32, where idx = nonces already dispatched. Valid lanes = min(NUM_CORES, nonce_count-idx); invalid lanes are not started. Pulse start for 1 cycle.
- BATCH_WAIT: wait until every started core has asserted done. Core latency is not fixed.
- WRITE, dump mode: write H0 of valid lanes in lane order, one word per cycle. Address = output_addr + idx + k, modulo 2^ADDR_W. mem_we=1 only on those cycles.
- WRITE, search mode: find the lowest valid lane with H0 < target (strict, unsigned). On a hit: write the nonce to output_addr and H0 to output_addr+1, set found=1, found_nonce=nonce, go to DONE. Remaining nonces are skipped. No hit: no write, continue.
- After the last batch, go to DONE. Search with no hit ends with found=0 and nothing written.
- idx is 33-bit internally, so nonce_count=2^32-1 terminates.

Decomposition:
- Package bitcoin_pkg: state enum, HEADER_WORDS=19, SHA256 K constants, IV constants.
- One sub-module, bitcoin_sha_core: start/done handshake. Inputs are header[19], nonce and nonce position word 3 of block 2. Output is the final H0. NUM_CORES instances are generated.

Test Plan:
- Dump, nonce_base=0, count=16, NUM_CORES=16: 16 writes at output_addr..+15. Each word must match the golden model's H0 for nonces 0..15, and done=1.
- Dump, nonce_base=0xFFFFFFFE, count=20: nonces wrap to 0..17. Two batches, second has 4 valid lanes. Exactly 20 writes, no others.
- Search, target=0xFFFFFFFF, base=100: hit on lane 0. Writes 100 at output_addr and H0 at output_addr+1; found=1, found_nonce=100. No further batches start.
- Search, target=0: no hit over count=40. Zero writes, done=1, found=0.
- nonce_count=0: done=1 within 2 cycles of start, with no reads or writes.
- Reset asserted during BATCH_WAIT, then a new start: no write in between. The second run's results are identical to a clean run.
